// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus unit.
// RIB field widths are also used by the fetch bus master.
package lsu_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;
  localparam int RIB_BE_W   = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } lsu_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    case (size)
      SIZE_B:  m = 1'b0;
      SIZE_H:  m = lo[0];
      SIZE_W:  m = |lo;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [RIB_BE_W-1:0] lsu_be(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [RIB_BE_W-1:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << lo;
      SIZE_H:  be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [RIB_DATA_W-1:0] lsu_wdata(
    input logic [1:0]            size,
    input logic [RIB_DATA_W-1:0] wdata
  );
    logic [RIB_DATA_W-1:0] d;
    case (size)
      SIZE_B:  d = {4{wdata[7:0]}};
      SIZE_H:  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_timeout_cnt.sv
// Bus watchdog: cleared on state entry, counts while enabled.
// expired_o marks the LIMIT-th cycle spent in a bus-wait state.
module lsu_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lsu_bus_unit.sv
// Memory-access stage: drives the RIB data bus for one
// load/store at a time and stalls the pipeline until done.
module lsu_bus_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = RIB_ADDR_W,
  parameter int DATA_W  = RIB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [1:0]          mem_size_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                rib_req_o,
  output logic                rib_we_o,
  output logic [ADDR_W-1:0]   rib_addr_o,
  output logic [RIB_BE_W-1:0] rib_be_o,
  output logic [DATA_W-1:0]   rib_wdata_o,
  input  logic                rib_gnt_i,
  input  logic                rib_rvalid_i,
  input  logic [DATA_W-1:0]   rib_rdata_i,
  output logic                stall_o,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic [ADDR_W-1:0]   mem_raddr_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mis;
  logic              cnt_clr;
  logic              cnt_en;
  logic              expired;

  assign mis = misaligned(mem_size_i, mem_addr_i[1:0]);

  // Counter restarts whenever a bus-wait state is (re)entered.
  assign cnt_clr = (state_q == IDLE)
                 | ((state_q == REQ) & rib_gnt_i)
                 | ((state_q == WAIT) & flush_i);
  assign cnt_en  = (state_q != IDLE);

  lsu_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  // Pipeline hold; released in the completion cycle.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:    stall_o = mem_req_i & ~flush_i & ~mis
                       & ~mem_rvalid_o;
      REQ:     stall_o = 1'b1;
      WAIT:    stall_o = 1'b1;
      DRAIN:   stall_o = mem_req_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Bus handshake FSM with registered bus and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rib_req_o    <= 1'b0;
      rib_we_o     <= 1'b0;
      rib_addr_o   <= '0;
      rib_be_o     <= '0;
      rib_wdata_o  <= '0;
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_raddr_o  <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      mem_rvalid_o <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req_i && !flush_i) begin
            if (mis) begin
              misalign_o <= 1'b1;
            end else begin
              state_q     <= REQ;
              rib_req_o   <= 1'b1;
              rib_we_o    <= mem_we_i;
              rib_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              rib_be_o    <= lsu_be(mem_size_i, mem_addr_i[1:0]);
              rib_wdata_o <= lsu_wdata(mem_size_i, mem_wdata_i);
              addr_q      <= mem_addr_i;
            end
          end
        end
        REQ: begin
          if (rib_gnt_i) begin
            rib_req_o <= 1'b0;
            if (rib_rvalid_i) begin
              // A squashed access still consumes its response.
              state_q <= IDLE;
              if (!flush_i) begin
                mem_rvalid_o <= 1'b1;
                mem_rdata_o  <= rib_we_o ? '0 : rib_rdata_i;
                mem_raddr_o  <= addr_q;
              end
            end else begin
              state_q <= flush_i ? DRAIN : WAIT;
            end
          end else if (flush_i) begin
            rib_req_o <= 1'b0;
            state_q   <= IDLE;
          end else if (expired) begin
            rib_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            state_q   <= IDLE;
          end
        end
        WAIT: begin
          if (rib_rvalid_i) begin
            state_q <= IDLE;
            if (!flush_i) begin
              mem_rvalid_o <= 1'b1;
              mem_rdata_o  <= rib_we_o ? '0 : rib_rdata_i;
              mem_raddr_o  <= addr_q;
            end
          end else if (flush_i) begin
            state_q <= DRAIN;
          end else if (expired) begin
            bus_err_o <= 1'b1;
            state_q   <= IDLE;
          end
        end
        DRAIN: begin
          if (rib_rvalid_i || expired) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
